// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Load-use bubble, memory-wait freeze and branch flush control.
//            Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hazard_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam logic [15:0] c_timeout = 16'(TIMEOUT);

  generate
    if (TIMEOUT < 1 || TIMEOUT > 65535 || CNT_W < 1) begin : g_param_check
      $error("hazard_stall_ctrl: TIMEOUT must be 1..65535 and CNT_W >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_wait_cnt, w_wait_cnt_nxt;
  logic        r_mem_timeout, w_mem_timeout_nxt;
  logic        w_mem_stall;
  logic        w_load_use;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 16'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= w_mem_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_mem_timeout_nxt = r_mem_timeout;
    case (r_state)
      ST_RUN: begin
        if (dmem_req && !dmem_ack) begin
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = 16'd0;
        end else if (r_wait_cnt == c_timeout) begin
          w_state_nxt       = ST_ERROR;
          w_mem_timeout_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end
      end
      ST_ERROR: begin
        // Only reset_n leaves ERROR.
        w_state_nxt = ST_ERROR;
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = 16'd0;
      end
    endcase
  end

  assign w_mem_stall = ((r_state == ST_RUN) && dmem_req && !dmem_ack) ||
                       ((r_state == ST_MEM_WAIT) && !dmem_ack) ||
                       (r_state == ST_ERROR);

  assign w_load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  // Freeze beats branch beats load-use; a squashed younger instr needs no stall.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (w_mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles, r_bubble_count, r_flush_count;

  // A bubble without a flush is exactly the load-use case.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
      r_bubble_count <= '0;
      r_flush_count  <= '0;
    end else begin
      if (pipe_freeze && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (idex_bubble && !ifid_flush && (r_bubble_count != '1))
        r_bubble_count <= r_bubble_count + 1'b1;
      if (ifid_flush && (r_flush_count != '1))
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign bubble_count = r_bubble_count;
  assign flush_count  = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Scoreboard bench for hazard_stall_ctrl (TIMEOUT=5).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_stall_ctrl;

  localparam int c_timeout = 5;
  localparam int c_cnt_w   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, idex_memread, branch_taken, dmem_req, dmem_ack;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [c_cnt_w-1:0] stall_cycles, bubble_count, flush_count;
`endif

  hazard_stall_ctrl #(.TIMEOUT(c_timeout), .CNT_W(c_cnt_w)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ack     (dmem_ack),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .pipe_freeze  (pipe_freeze),
    .mem_timeout  (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .bubble_count (bubble_count),
    .flush_count  (flush_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Expected output word: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout}
  logic [5:0] exp_q[$];

  // Reference model state: 0 RUN, 1 MEM_WAIT, 2 ERROR
  int   m_state;
  int   m_cnt;
  logic m_to;
  int   m_stall, m_bubble, m_flush;
  int   freeze_seen;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_state  = 0;
    m_cnt    = 0;
    m_to     = 1'b0;
    m_stall  = 0;
    m_bubble = 0;
    m_flush  = 0;
    exp_q.delete();
  endtask

  task automatic drive_idle();
    ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
    idex_memread = 1'b0; idex_rt = 5'd0;
    branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic check_counters(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall_cnt"},  64'(stall_cycles), 64'(m_stall));
    check({tag, "_bubble_cnt"}, 64'(bubble_count), 64'(m_bubble));
    check({tag, "_flush_cnt"},  64'(flush_count),  64'(m_flush));
`endif
  endtask

  task automatic step(input string tag,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic mr, input logic [4:0] lrt,
                      input logic br, input logic req, input logic ack);
    logic       stall, lu;
    logic [5:0] e, got;
    @(negedge clk);
    ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = urt;
    idex_memread = mr; idex_rt = lrt;
    branch_taken = br; dmem_req = req; dmem_ack = ack;

    stall = (m_state == 0 && req && !ack) || (m_state == 1 && !ack) || (m_state == 2);
    lu    = mr && (lrt != 5'd0) && ((lrt == rs) || (urt && (lrt == rt)));
    if (stall)   e = {5'b00001, m_to};
    else if (br) e = {5'b11110, m_to};
    else if (lu) e = {5'b00010, m_to};
    else         e = {5'b11000, m_to};
    exp_q.push_back(e);

    if (stall)   m_stall++;
    else if (br) m_flush++;
    else if (lu) m_bubble++;

    case (m_state)
      0: if (req && !ack) begin m_state = 1; m_cnt = 1; end
      1: begin
        if (ack) m_state = 0;
        else if (m_cnt == c_timeout) begin m_state = 2; m_to = 1'b1; end
        else m_cnt++;
      end
      default: m_state = 2;
    endcase

    #2;
    got = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout};
    if (pipe_freeze) freeze_seen++;
    check(tag, 64'(got), 64'(exp_q.pop_front()));
    @(posedge clk);
    #1;
    check_counters(tag);
  endtask

  // Asserts reset between edges and checks the outputs before any clock arrives.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    drive_idle();
    reset_n = 1'b0;
    #1;
    check({tag, "_outs"}, 64'({pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout}),
          64'(6'b110000));
    model_clear();
    check_counters(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_clear();
    drive_idle();
    reset_n = 1'b0;
    #1;
    check("reset_outs", 64'({pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout}),
          64'(6'b110000));
    check_counters("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    //    tag              rs     rt     urt   mr    lrt    br    req   ack
    step("idle",          5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    step("lu_rs",         5'd8,  5'd3,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0);
    step("lu_rs_after",   5'd8,  5'd3,  1'b0, 1'b0, 5'd8,  1'b0, 1'b0, 1'b0);
    step("lu_zero_reg",   5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0);
    step("lu_rt_unused",  5'd4,  5'd9,  1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0);
    step("lu_rt_used",    5'd4,  5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0);
    step("br_over_lu",    5'd7,  5'd0,  1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0);
    step("br_alone",      5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0);
    step("ack_first",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1);

    // Ack on the 4th cycle: three frozen cycles; load-use held and branch ignored meanwhile.
    freeze_seen = 0;
    step("mw_c1",         5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b1, 1'b0);
    step("mw_c2",         5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b1, 1'b1, 1'b0);
    step("mw_c3",         5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b1, 1'b0);
    step("mw_ack",        5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b1, 1'b1);
    check("mw_freeze_len", 64'(freeze_seen), 64'(3));
    step("mw_after",      5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      step("rand",
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end

    async_reset("rst_any");
    step("wait_then_rst", 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0);
    step("wait_then_rst", 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0);
    async_reset("rst_mid_wait");

    // Held-off ack: 1 RUN cycle + 5 MEM_WAIT cycles, then ERROR.
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("to_not_early", 64'(mem_timeout), 64'(0));
      step("to_wait",     5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0);
    end
    check("to_flag", 64'(mem_timeout), 64'(1));
    step("err_hold",      5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1);
    step("err_hold_br",   5'd3,  5'd0,  1'b0, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0);
    async_reset("rst_error");
    step("post_err",      5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
